// File: rtl/icache_burst_fetch_ctrl_pkg.sv
// Shared constants for the instruction-fetch burst controller: FSM state
// encodings, fixed AXI read-channel attributes and a small sizing helper.
package icache_fetch_pkg;

   // FSM state encodings, kept as plain constants for legacy tools
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ADDR  = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   // Fixed AXI attributes of every fetch burst
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [3:0] AXI_ARCACHE    = 4'd7;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // AXI size code for a beat of data_w bits
   function automatic logic [2:0] axi_size(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/icache_burst_fetch_ctrl_if.sv
// AXI read address/data channels between the fetch controller (master)
// and the instruction cache read port (slave).
interface icache_burst_fetch_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [3:0]        arcache;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;

   modport master (
      output araddr, arvalid, arlen, arsize, arburst, arcache, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );

   modport slave (
      input  araddr, arvalid, arlen, arsize, arburst, arcache, rready,
      output arready, rvalid, rdata, rresp, rlast
   );
endinterface

// File: rtl/icache_burst_fetch_ctrl_fifo.sv
// Synchronous instruction buffer with same-cycle flush and a free-entry
// count used by the controller to guarantee room before issuing a burst.
module fetch_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 65
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     free
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push, do_pop;

   // Flush wins over both push and pop
   assign do_push = push && !flush;
   assign do_pop  = pop && !flush && (count != '0);

   assign empty = (count == '0);
   assign free  = CNT_W'(DEPTH) - count;
   assign rdata = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage write port
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; validity is carried entirely by count.
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/icache_burst_fetch_ctrl.sv
// Instruction-fetch controller: issues block-aligned INCR bursts, buffers
// returned words with their PCs, and handles jump/ecall redirects by
// flushing the buffer and discarding stale beats.
module icache_burst_fetch_ctrl
   import icache_fetch_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                BURST_LEN  = 4,
   parameter int                FIFO_DEPTH = 8,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter logic [ADDR_W-1:0] TRAP_VEC   = 'd200
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cache_rst_done,
   input  logic                 stop,
   input  logic                 j_accept,
   input  logic [ADDR_W-1:0]    j_addr,
   input  logic                 ecall,
   icache_burst_fetch_ctrl_if.master axi,
   output logic                 fetch_valid,
   input  logic                 fetch_ready,
   output logic [ADDR_W-1:0]    fetch_pc,
   output logic [DATA_W-1:0]    fetch_instr,
   output logic                 fetch_err
);
   localparam int BPB      = DATA_W / 8;
   localparam int WORD_LSB = $clog2(BPB);
   localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
      logic              err;
   } fetch_entry_t;

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc_q, araddr_q, beat_pc;
   logic [7:0]        arlen_q, beats;
   logic [ADDR_W-1:0] word_off, target;
   logic              drop_q, redirect, can_issue, push, pop, empty;
   logic [CNT_W-1:0]  free;
   fetch_entry_t      wr_entry, rd_entry;

   // Redirect priority: jump over ecall
   assign redirect = j_accept || ecall;
   assign target   = j_accept ? j_addr : TRAP_VEC;

   // Beats left to the end of the current BURST_LEN-aligned block
   assign word_off  = (pc_q >> WORD_LSB) & ADDR_W'(BURST_LEN - 1);
   assign beats     = 8'(BURST_LEN) - 8'(word_off);
   assign can_issue = cache_rst_done && !stop && !redirect && (32'(free) >= 32'(beats));

   assign axi.araddr  = araddr_q;
   assign axi.arlen   = arlen_q;
   assign axi.arvalid = (state == ST_ADDR);
   assign axi.arsize  = axi_size(DATA_W);
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.arcache = AXI_ARCACHE;
   assign axi.rready  = (state == ST_DATA) || (state == ST_DRAIN);

   assign push     = (state == ST_DATA) && axi.rvalid && !redirect;
   assign wr_entry = '{pc: beat_pc, instr: axi.rdata, err: (axi.rresp != AXI_RESP_OKAY)};

   assign fetch_valid = !empty && !stop;
   assign pop         = fetch_valid && fetch_ready;
   assign fetch_pc    = rd_entry.pc;
   assign fetch_instr = rd_entry.instr;
   assign fetch_err   = rd_entry.err;

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .rdata (rd_entry),
      .empty (empty),
      .free  (free)
   );

   // Burst sequencing, fetch PC tracking and redirect handling
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         pc_q     <= RESET_PC;
         araddr_q <= RESET_PC;
         arlen_q  <= '0;
         beat_pc  <= RESET_PC;
         drop_q   <= 1'b0;
      end else begin
         if (redirect) pc_q <= target;
         case (state)
            ST_IDLE: begin
               if (can_issue) begin
                  state    <= ST_ADDR;
                  araddr_q <= pc_q;
                  arlen_q  <= beats - 8'd1;
               end
            end
            ST_ADDR: begin
               // An issued AR cannot be withdrawn; remember it went stale
               if (redirect) drop_q <= 1'b1;
               if (axi.arready) begin
                  beat_pc <= araddr_q;
                  drop_q  <= 1'b0;
                  state   <= (drop_q || redirect) ? ST_DRAIN : ST_DATA;
               end
            end
            ST_DATA: begin
               if (redirect) begin
                  state <= (axi.rvalid && axi.rlast) ? ST_IDLE : ST_DRAIN;
               end else if (axi.rvalid) begin
                  beat_pc <= beat_pc + ADDR_W'(BPB);
                  if (axi.rlast) begin
                     state <= ST_IDLE;
                     pc_q  <= beat_pc + ADDR_W'(BPB);
                  end
               end
            end
            default: begin
               if (axi.rvalid && axi.rlast) state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_icache_burst_fetch_ctrl.sv
// Directed bench for icache_burst_fetch_ctrl with a zero-latency AXI read
// responder and logs of AR handshakes and accepted instructions.
module tb_icache_burst_fetch_ctrl;
   localparam logic [31:0] KEY = 32'hCAFE_0000;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } ar_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        err;
   } fe_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cache_rst_done = 1'b0;
   logic        stop = 1'b0;
   logic        j_accept = 1'b0;
   logic [31:0] j_addr = '0;
   logic        ecall = 1'b0;
   logic        fetch_ready = 1'b1;
   logic        fetch_valid, fetch_err;
   logic [31:0] fetch_pc, fetch_instr;

   logic        arready = 1'b1;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = '0;
   logic        rlast = 1'b0;

   logic        busy = 1'b0;
   logic [31:0] rsp_addr = '0;
   int          rsp_left = 0;
   logic        ar_fire_q = 1'b0, r_fire_q = 1'b0;
   logic [31:0] ar_addr_q = '0;
   logic [7:0]  ar_len_q = '0;
   logic [31:0] err_addr = 32'hFFFF_FFFF;

   ar_t ar_log[$];
   fe_t fetch_log[$];
   int  tests = 0;
   int  fails = 0;

   always #5 clk = ~clk;

   icache_burst_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) axi ();

   assign axi.arready = arready;
   assign axi.rvalid  = rvalid;
   assign axi.rdata   = rdata;
   assign axi.rresp   = rresp;
   assign axi.rlast   = rlast;

   icache_burst_fetch_ctrl #(
      .ADDR_W(32), .DATA_W(32), .BURST_LEN(4), .FIFO_DEPTH(8),
      .RESET_PC(32'h0), .TRAP_VEC(32'd200)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cache_rst_done(cache_rst_done), .stop(stop),
      .j_accept(j_accept), .j_addr(j_addr), .ecall(ecall), .axi(axi),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
      .fetch_instr(fetch_instr), .fetch_err(fetch_err)
   );

   // Log handshakes that will complete at the coming rising edge
   always @(negedge clk) begin
      ar_fire_q = rst_n && axi.arvalid && arready;
      r_fire_q  = rst_n && rvalid && axi.rready;
      ar_addr_q = axi.araddr;
      ar_len_q  = axi.arlen;
      if (ar_fire_q) ar_log.push_back('{addr: axi.araddr, len: axi.arlen});
      if (rst_n && fetch_valid && fetch_ready)
         fetch_log.push_back('{pc: fetch_pc, instr: fetch_instr, err: fetch_err});
   end

   // Zero-latency read responder: beats follow the AR handshake back to back
   always begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         busy = 1'b0;
      end else begin
         if (r_fire_q) begin
            rsp_addr = rsp_addr + 32'd4;
            rsp_left = rsp_left - 1;
            if (rsp_left == 0) busy = 1'b0;
         end
         if (ar_fire_q) begin
            busy     = 1'b1;
            rsp_addr = ar_addr_q;
            rsp_left = int'(ar_len_q) + 1;
         end
      end
      rvalid = busy;
      rdata  = busy ? (rsp_addr ^ KEY) : '0;
      rlast  = busy && (rsp_left == 1);
      rresp  = (busy && rsp_addr == err_addr) ? 2'b10 : 2'b00;
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [39:0] ar_at(input int i);
      if (i < ar_log.size()) return {ar_log[i].addr, ar_log[i].len};
      return 'x;
   endfunction

   function automatic logic [31:0] pc_at(input int i);
      if (i < fetch_log.size()) return fetch_log[i].pc;
      return 'x;
   endfunction

   task automatic wait_ar(input int n, input string tag);
      int k = 0;
      while (ar_log.size() < n && k < 300) begin tick(); k++; end
      if (ar_log.size() < n) check(tag, 64'(ar_log.size()), 64'(n));
   endtask

   task automatic wait_fetch(input int n, input string tag);
      int k = 0;
      while (fetch_log.size() < n && k < 300) begin tick(); k++; end
      if (fetch_log.size() < n) check(tag, 64'(fetch_log.size()), 64'(n));
   endtask

   task automatic clear_logs();
      ar_log.delete();
      fetch_log.delete();
   endtask

   initial begin
      logic found;

      // Reset values
      repeat (3) tick();
      check("rst_arvalid", axi.arvalid, 1'b0);
      check("rst_rready", axi.rready, 1'b0);
      check("rst_fetch_valid", fetch_valid, 1'b0);
      check("rst_arlen", axi.arlen, 8'd0);
      check("rst_araddr", axi.araddr, 32'h0);
      check("rst_arsize", axi.arsize, 3'd2);
      rst_n = 1'b1;
      repeat (5) tick();
      check("no_ar_before_cache_ready", 64'(ar_log.size()), 64'd0);

      // First bursts from RESET_PC; beat 0x18 returns SLVERR; stop holds output
      err_addr = 32'h18;
      cache_rst_done = 1'b1;
      wait_ar(2, "b_wait_ar");
      stop = 1'b1;
      repeat (10) tick();
      check("b_ar0", ar_at(0), {32'h0, 8'd3});
      check("b_ar1", ar_at(1), {32'h10, 8'd3});
      check("b_no_ar_while_stop", 64'(ar_log.size()), 64'd2);
      check("b_fetch_count_before_stop", 64'(fetch_log.size()), 64'd4);
      for (int i = 0; i < 4; i++) check("b_pc", pc_at(i), 32'(4 * i));
      check("b_instr2", fetch_log[2].instr, 32'h8 ^ KEY);
      check("b_stop_masks_valid", fetch_valid, 1'b0);
      stop = 1'b0;
      #1;
      check("b_valid_after_stop", fetch_valid, 1'b1);
      wait_fetch(8, "b_wait_fetch");
      for (int i = 4; i < 8; i++) check("b_pc_burst1", pc_at(i), 32'(4 * i));
      check("b_err_0x10", fetch_log[4].err, 1'b0);
      check("b_err_0x14", fetch_log[5].err, 1'b0);
      check("b_err_0x18", fetch_log[6].err, 1'b1);
      check("b_err_0x1c", fetch_log[7].err, 1'b0);
      err_addr = 32'hFFFF_FFFF;

      // Park in IDLE, then jump to 0x38: truncated burst then aligned burst
      stop = 1'b1;
      repeat (12) tick();
      j_accept = 1'b1;
      j_addr = 32'h38;
      tick();
      j_accept = 1'b0;
      stop = 1'b0;
      clear_logs();
      #1;
      check("c_flushed", fetch_valid, 1'b0);
      wait_ar(2, "c_wait_ar");
      check("c_ar0", ar_at(0), {32'h38, 8'd1});
      check("c_ar1", ar_at(1), {32'h40, 8'd3});
      wait_fetch(3, "c_wait_fetch");
      check("c_pc0", pc_at(0), 32'h38);
      check("c_pc1", pc_at(1), 32'h3C);
      check("c_pc2", pc_at(2), 32'h40);

      // Jump on beat 2 of an aligned 4-beat burst
      found = 1'b0;
      for (int k = 0; k < 200 && !found; k++) begin
         tick();
         if (rvalid && axi.rready && rsp_addr[3:0] == 4'h4) found = 1'b1;
      end
      check("d_found_beat2", found, 1'b1);
      j_accept = 1'b1;
      j_addr = 32'h100;
      tick();
      j_accept = 1'b0;
      clear_logs();
      #1;
      check("d_flushed", fetch_valid, 1'b0);
      wait_fetch(4, "d_wait_fetch");
      check("d_ar0", ar_at(0), {32'h100, 8'd3});
      for (int i = 0; i < 4; i++) check("d_pc", pc_at(i), 32'h100 + 32'(4 * i));

      // Jump and ecall together: jump wins
      j_accept = 1'b1;
      ecall = 1'b1;
      j_addr = 32'h80;
      tick();
      j_accept = 1'b0;
      ecall = 1'b0;
      clear_logs();
      #1;
      check("e_flushed", fetch_valid, 1'b0);
      wait_fetch(1, "e_wait_fetch");
      check("e_ar0", ar_at(0), {32'h80, 8'd3});
      check("e_pc0", pc_at(0), 32'h80);

      // ecall alone: trap vector 200 is two beats from its block end
      ecall = 1'b1;
      tick();
      ecall = 1'b0;
      clear_logs();
      wait_fetch(3, "e2_wait_fetch");
      check("e2_ar0", ar_at(0), {32'hC8, 8'd1});
      check("e2_ar1", ar_at(1), {32'hD0, 8'd3});
      check("e2_pc0", pc_at(0), 32'hC8);
      check("e2_pc1", pc_at(1), 32'hCC);
      check("e2_pc2", pc_at(2), 32'hD0);

      // Decode backpressure fills the buffer; issue stops when free < beats
      j_accept = 1'b1;
      j_addr = 32'h200;
      fetch_ready = 1'b0;
      tick();
      j_accept = 1'b0;
      clear_logs();
      repeat (30) tick();
      check("f_ar_count_full", 64'(ar_log.size()), 64'd2);
      check("f_ar0", ar_at(0), {32'h200, 8'd3});
      check("f_ar1", ar_at(1), {32'h210, 8'd3});
      check("f_valid_full", fetch_valid, 1'b1);
      check("f_pc_head", fetch_pc, 32'h200);
      fetch_ready = 1'b1;
      wait_fetch(12, "f_wait_fetch");
      for (int i = 0; i < 12; i++) check("f_pc_seq", pc_at(i), 32'h200 + 32'(4 * i));
      check("f_ar2", ar_at(2), {32'h220, 8'd3});
      check("f_instr11", fetch_log[11].instr, 32'h22C ^ KEY);

      // Reset in the middle of a burst abandons it
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         tick();
         if (axi.rready) found = 1'b1;
      end
      check("g_found_burst", found, 1'b1);
      rst_n = 1'b0;
      #1;
      check("g_rst_arvalid", axi.arvalid, 1'b0);
      check("g_rst_rready", axi.rready, 1'b0);
      check("g_rst_fetch_valid", fetch_valid, 1'b0);
      check("g_rst_araddr", axi.araddr, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      clear_logs();
      wait_fetch(1, "g_wait_fetch");
      check("g_ar0", ar_at(0), {32'h0, 8'd3});
      check("g_pc0", pc_at(0), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
